// File: rtl/ccd_adc_emulator.sv
// CCD sensor + serial ADC emulator.
// Follows the scanner's CCD clocks to keep a pixel index and a line count,
// and answers each ADC read with a 16-bit test-pattern word, MSB first.
`timescale 1ns/1ps
module ccd_adc_emulator #(
    parameter int unsigned DARK_PIXELS = 32,
    parameter logic [15:0] DARK_LEVEL  = 16'h0100,
    parameter logic [15:0] LIGHT_LEVEL = 16'hC000
) (
    input  logic        clk_80M,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [15:0] const_val,
    input  logic        ccd_p1,
    input  logic        ccd_sh,
    input  logic        adc_cs,
    input  logic        adc_sclk,
    output logic        adc_sdo,
    output logic [11:0] pix_idx,
    output logic [15:0] line_cnt,
    output logic [15:0] word_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] PAT_RAMP    = 2'b00;
    localparam logic [1:0] PAT_CONST   = 2'b01;
    localparam logic [1:0] PAT_DARK    = 2'b10;
    localparam logic [1:0] PAT_CHECKER = 2'b11;

    // Test-pattern word for the current pixel/line position.
    function automatic logic [15:0] pattern_word(
        input logic [1:0]  pat,
        input logic [15:0] cval,
        input logic [11:0] pix,
        input logic [15:0] line
    );
        logic [31:0] pix_ext;
        logic [15:0] w;
        pix_ext = {20'd0, pix};
        case (pat)
            PAT_RAMP:    w = {pix, line[3:0]};
            PAT_CONST:   w = cval;
            PAT_DARK:    w = (pix_ext < DARK_PIXELS) ? DARK_LEVEL : LIGHT_LEVEL;
            PAT_CHECKER: w = (pix[0] ^ line[0]) ? 16'hFFFF : 16'h0000;
            default:     w = 16'h0000;
        endcase
        return w;
    endfunction

    // Previous-cycle copies of the control inputs (already in clk_80M domain).
    logic p1_q, sh_q, cs_q, sclk_q;

    logic [11:0] pix_q,   pix_d;
    logic [15:0] line_q,  line_d;
    logic [15:0] wcnt_q,  wcnt_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  bit_q,   bit_d;
    logic        sdo_q,   sdo_d;

    logic p1_rise_s, sh_rise_s, cs_fall_s, cs_rise_s, sclk_fall_s;

    // Edge detection against last cycle's value; sclk only counts while cs is low.
    always_comb begin
        p1_rise_s   = ccd_p1 & ~p1_q;
        sh_rise_s   = ccd_sh & ~sh_q;
        cs_fall_s   = cs_q & ~adc_cs;
        cs_rise_s   = ~cs_q & adc_cs;
        sclk_fall_s = sclk_q & ~adc_sclk & ~adc_cs;
    end

    // Edge-detect history; cs and p1 idle high so reset must not fake an edge.
    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            p1_q   <= 1'b1;
            sh_q   <= 1'b0;
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            p1_q   <= ccd_p1;
            sh_q   <= ccd_sh;
            cs_q   <= adc_cs;
            sclk_q <= adc_sclk;
        end
    end

    // Pixel/line tracking: shift gate restarts the line and beats a coincident p1.
    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (!en) begin
            pix_d  = 12'd0;
            line_d = 16'd0;
        end else if (sh_rise_s) begin
            pix_d  = 12'd0;
            line_d = line_q + 16'd1;
        end else if (p1_rise_s) begin
            if (pix_q != 12'hFFF) begin
                pix_d = pix_q + 12'd1;
            end else begin
                pix_d = pix_q;
            end
        end else begin
            pix_d  = pix_q;
            line_d = line_q;
        end
    end

    // Serializer: word latched at cs fall, one bit per sclk fall, cs rise aborts.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        sdo_d   = sdo_q;
        wcnt_d  = wcnt_q;
        if (!en) begin
            state_d = ST_IDLE;
            shreg_d = 16'd0;
            bit_d   = 4'd0;
            sdo_d   = 1'b0;
            wcnt_d  = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        shreg_d = pattern_word(pattern, const_val, pix_q, line_q);
                        sdo_d   = shreg_d[15];
                        bit_d   = 4'd15;
                        state_d = ST_SHIFT;
                    end else begin
                        sdo_d   = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        sdo_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (sclk_fall_s) begin
                        if (bit_q != 4'd0) begin
                            shreg_d = {shreg_q[14:0], 1'b0};
                            sdo_d   = shreg_q[14];
                            bit_d   = bit_q - 4'd1;
                        end else begin
                            wcnt_d  = wcnt_q + 16'd1;
                            sdo_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    sdo_d = 1'b0;
                    if (cs_rise_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    sdo_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and serial output register.
    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            pix_q   <= 12'd0;
            line_q  <= 16'd0;
            wcnt_q  <= 16'd0;
            state_q <= ST_IDLE;
            shreg_q <= 16'd0;
            bit_q   <= 4'd0;
            sdo_q   <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            line_q  <= line_d;
            wcnt_q  <= wcnt_d;
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            sdo_q   <= sdo_d;
        end
    end

    assign adc_sdo  = sdo_q;
    assign pix_idx  = pix_q;
    assign line_cnt = line_q;
    assign word_cnt = wcnt_q;

endmodule

// File: doc/ccd_adc_emulator.md
CCD_ADC_EMULATOR -- requirements
Module: ccd_adc_emulator

Interface
REQ-001 The block SHALL be a synthesizable, same-clock emulator of the CCD sensor plus serial ADC, driving adc_sdo in response to the scanner's CCD clocks and ADC reads, for bench and hardware bring-up without a sensor.
REQ-002 Parameter DARK_PIXELS, default 32, SHALL set the number of leading dark pixels per line.
REQ-003 Parameter DARK_LEVEL, default 16'h0100, SHALL set the dark-pixel code.
REQ-004 Parameter LIGHT_LEVEL, default 16'hC000, SHALL set the non-dark code in dark-pattern mode.
REQ-005 clk_80M  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  enable; 0 = hold idle state.
REQ-008 pattern  input  2  00 ramp, 01 constant, 10 dark/light, 11 checker.
REQ-009 const_val  input  16  code used in constant mode.
REQ-010 ccd_p1, ccd_sh  input  1 each  CCD phase-1 and shift gate, registered in clk_80M domain.
REQ-011 adc_cs, adc_sclk  input  1 each  ADC chip select (active-low) and serial clock, registered in clk_80M domain.
REQ-012 adc_sdo  output  1  serial data, MSB first.
REQ-013 pix_idx  output  12  current pixel index; line_cnt  output  16  lines since enable; word_cnt  output  16  completed 16-bit words.

Function
REQ-014 Edge detection SHALL compare each input with its value registered one cycle earlier; no extra synchronizers, since the inputs are clk_80M-registered.
REQ-015 On an ccd_sh rising edge: pix_idx SHALL become 0 and line_cnt SHALL increment, wrapping 65535->0.
REQ-016 Otherwise, on a ccd_p1 rising edge, pix_idx SHALL increment, saturating at 4095.
REQ-017 Simultaneous sh and p1 rising edges: the sh rule SHALL win.
REQ-018 Word value SHALL be computed from pix_idx and line_cnt as they stand in the cycle the cs falling edge is detected:
- ramp: {pix_idx, line_cnt[3:0]}
- constant: const_val
- dark: DARK_LEVEL if pix_idx < DARK_PIXELS, else LIGHT_LEVEL
- checker: 16'hFFFF if pix_idx[0]^line_cnt[0], else 16'h0000
REQ-019 The serializer FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-020 IDLE: adc_sdo=0; on a cs falling edge, load the word into the shift register, drive adc_sdo=word[15] on the next cycle, set bit_cnt=15, go to SHIFT.
REQ-021 SHIFT, on an sclk falling edge with bit_cnt>0: shift left and present the next bit on adc_sdo the following cycle; bit_cnt decrements.
REQ-022 SHIFT, on an sclk falling edge with bit_cnt=0: word_cnt SHALL increment (wrapping), adc_sdo=0, go to DONE.
REQ-023 DONE: adc_sdo SHALL hold 0 until a cs rising edge, then go to IDLE.
REQ-024 A cs rising edge in SHIFT SHALL abort to IDLE with adc_sdo=0, without incrementing word_cnt; it SHALL win over a simultaneous sclk falling edge.
REQ-025 sclk edges while cs is high SHALL be ignored.
REQ-026 Latency SHALL be: bit valid on adc_sdo 1 cycle after the cs-fall or sclk-fall detection edge; this meets a master that raises sclk 1 cycle after cs low and samples on its sclk-low cycle.
REQ-027 en=0 SHALL synchronously clear pix_idx, line_cnt, word_cnt and the FSM (to IDLE), and force adc_sdo=0.
REQ-028 Changes to pattern or const_val mid-word SHALL affect only the next word.

Reset
REQ-029 While rst_n=0, adc_sdo SHALL be 0, pix_idx, line_cnt and word_cnt SHALL be 0, the FSM SHALL be in IDLE, and all edge-detect registers SHALL be cleared to 0 except those for adc_cs and ccd_p1, which SHALL be cleared to 1.
REQ-030 Reset asserted mid-word SHALL abort immediately; after release the block SHALL wait for a fresh cs falling edge.

Verification
REQ-031 Ramp mode, line_cnt=3, 5 p1 rises, then a 16-sclk read -> captured word 16'h0053; word_cnt=1.
REQ-032 Constant mode, const_val=16'hA5C3, read using the scanner timing (sclk high 1 cycle, low 1 cycle) -> every bit matches MSB first; adc_sdo=0 after bit 0.
REQ-033 Dark mode, reads at pix_idx 31 and 32 -> 16'h0100 then 16'hC000.
REQ-034 cs raised after 7 sclk falls, then a new read -> second word complete and correct; word_cnt increments once only.
REQ-035 sh rise coincident with a p1 rise -> pix_idx=0 and line_cnt+1; 4100 p1 rises -> pix_idx saturates at 4095.
REQ-036 rst_n pulsed low mid-word, and separately en dropped mid-word -> adc_sdo=0 immediately or next cycle respectively, all counters 0, and the next read correct.
